// File: rtl/uart_tx_scheduler.sv
// Two-port round-robin scheduler driving one 8N1 UART transmit line.
// The baud counter restarts at every frame, so bit edges align to the ack cycle.
module uart_tx_scheduler #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CNT_W        = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [7:0] data0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baudCnt_q, baudCnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       shift_q, shift_d;
    logic             lastGrant_q, lastGrant_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             done_q, done_d;
    logic             bitEnd;
    logic             grant1;

    assign bitEnd = (baudCnt_q == LAST_CNT);

    // lastGrant resets to port 1 so that port 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            baudCnt_q   <= '0;
            bitIdx_q    <= '0;
            shift_q     <= '0;
            lastGrant_q <= 1'b1;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            baudCnt_q   <= baudCnt_d;
            bitIdx_q    <= bitIdx_d;
            shift_q     <= shift_d;
            lastGrant_q <= lastGrant_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        baudCnt_d   = baudCnt_q;
        bitIdx_d    = bitIdx_q;
        shift_d     = shift_q;
        lastGrant_d = lastGrant_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        grant1      = req1 && (!req0 || !lastGrant_q);

        if (state_q != IDLE) begin
            baudCnt_d = bitEnd ? '0 : baudCnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (req0 || req1) begin
                    state_d     = START;
                    shift_d     = grant1 ? data1 : data0;
                    ack0_d      = !grant1;
                    ack1_d      = grant1;
                    tx_d        = 1'b0;
                    busy_d      = 1'b1;
                    baudCnt_d   = '0;
                    lastGrant_d = grant1;
                end
            end
            START: begin
                if (bitEnd) begin
                    state_d  = DATA;
                    tx_d     = shift_q[0];
                    bitIdx_d = '0;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    if (bitIdx_q != 3'd7) begin
                        shift_d  = {1'b0, shift_q[7:1]};
                        tx_d     = shift_q[1];
                        bitIdx_d = bitIdx_q + 3'd1;
                    end else begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bitEnd) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // done is registered, so it is raised when the next cycle is the last stop-bit cycle.
        done_d = (state_d == STOP) && (baudCnt_d == LAST_CNT);
    end

    assign ack0 = ack0_q;
    assign ack1 = ack1_q;
    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: stimulus queues expected frames,
// a monitor follows every ack through all ten bit slots and checks the line.
module tb_uart_tx_scheduler;

    localparam int N   = 4;
    localparam int GAP = 10 * N + 1;

    typedef struct {
        logic       port;
        logic [7:0] data;
        int         gap;
        bit         abort;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       req0;
    logic [7:0] data0;
    logic       req1;
    logic [7:0] data1;
    logic       ack0;
    logic       ack1;
    logic       tx;
    logic       busy;
    logic       done;

    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;
    int   lastAck  = 0;
    exp_t expQ[$];

    uart_tx_scheduler #(
        .CLKS_PER_BIT(N),
        .CNT_W       (13)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req0 (req0),
        .data0(data0),
        .req1 (req1),
        .data1(data1),
        .ack0 (ack0),
        .ack1 (ack1),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic pushExp(input logic port, input logic [7:0] data, input int gap, input bit abort);
        exp_t e;
        e.port  = port;
        e.data  = data;
        e.gap   = gap;
        e.abort = abort;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input int waitCycles, input logic r0, input logic [7:0] d0,
                                 input logic r1, input logic [7:0] d1);
        repeat (waitCycles) @(posedge clk);
        #1;
        req0  = r0;
        data0 = d0;
        req1  = r1;
        data1 = d1;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic waitAck(input logic port, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (port ? ack1 : ack0) seen = 1;
        end
        checkOutput(port ? "ack1 arrives" : "ack0 arrives", seen, 1);
    endtask

    task automatic waitDone(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        checkOutput("done arrives", seen, 1);
    endtask

    // Follows one frame from its ack cycle until the done cycle or a reset.
    task automatic trackFrame();
        exp_t e;
        bit   aborted = 0;
        logic expBit;
        if (expQ.size() == 0) begin
            checkOutput("unexpected ack", 1, 0);
            return;
        end
        e = expQ.pop_front();
        checkOutput("grant port", ack1, e.port);
        if (e.gap != 0) checkOutput("ack spacing", cycle - lastAck, e.gap);
        lastAck = cycle;
        for (int s = 0; s < 10 && !aborted; s++) begin
            for (int c = 0; c < N && !aborted; c++) begin
                if (s != 0 || c != 0) @(negedge clk);
                if (!rst_n) begin
                    aborted = 1;
                    checkOutput("reset tx", tx, 1);
                    checkOutput("reset busy", busy, 0);
                    checkOutput("reset done", done, 0);
                end else begin
                    expBit = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : e.data[s-1];
                    checkOutput($sformatf("tx slot%0d", s), tx, expBit);
                    checkOutput("frame busy", busy, 1);
                    checkOutput("frame done", done, (s == 9 && c == N - 1));
                    checkOutput("frame ack0", ack0, (s == 0 && c == 0 && e.port == 1'b0));
                    checkOutput("frame ack1", ack1, (s == 0 && c == 0 && e.port == 1'b1));
                end
            end
        end
        checkOutput("frame aborted", aborted, e.abort);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && (ack0 || ack1)) begin
                trackFrame();
            end else begin
                checkOutput("idle tx", tx, 1);
                checkOutput("idle busy", busy, 0);
                checkOutput("idle done", done, 0);
                checkOutput("idle ack0", ack0, 0);
                checkOutput("idle ack1", ack1, 0);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        data0 = 8'h00;
        data1 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] single byte A5 on port 0");
        pushExp(1'b0, 8'hA5, 0, 0);
        applyStimulus(1, 1'b1, 8'hA5, 1'b0, 8'h00);
        waitAck(1'b0, 10);
        applyStimulus(1, 1'b0, 8'hA5, 1'b0, 8'h00);
        waitDone(60);
        applyStimulus(3, 1'b0, 8'h00, 1'b0, 8'h00);

        $display("[TB] contention after reset");
        doReset();
        pushExp(1'b0, 8'h01, 0, 0);
        pushExp(1'b1, 8'h80, GAP, 0);
        applyStimulus(1, 1'b1, 8'h01, 1'b1, 8'h80);
        waitAck(1'b0, 10);
        applyStimulus(1, 1'b0, 8'h01, 1'b1, 8'h80);
        waitAck(1'b1, 60);
        applyStimulus(1, 1'b0, 8'h00, 1'b0, 8'h80);
        waitDone(60);

        $display("[TB] fairness over four frames");
        doReset();
        pushExp(1'b0, 8'h3C, 0, 0);
        pushExp(1'b1, 8'hC3, GAP, 0);
        pushExp(1'b0, 8'h3C, GAP, 0);
        pushExp(1'b1, 8'hC3, GAP, 0);
        applyStimulus(1, 1'b1, 8'h3C, 1'b1, 8'hC3);
        waitAck(1'b0, 10);
        waitAck(1'b1, 60);
        waitAck(1'b0, 60);
        waitAck(1'b1, 60);
        applyStimulus(1, 1'b0, 8'h3C, 1'b0, 8'hC3);
        waitDone(60);

        $display("[TB] late request on port 1");
        doReset();
        pushExp(1'b0, 8'h5A, 0, 0);
        applyStimulus(1, 1'b1, 8'h5A, 1'b0, 8'h00);
        waitAck(1'b0, 10);
        applyStimulus(1, 1'b0, 8'h5A, 1'b0, 8'h00);
        pushExp(1'b1, 8'hE7, GAP, 0);
        applyStimulus(14, 1'b0, 8'h5A, 1'b1, 8'hE7);
        waitAck(1'b1, 60);
        applyStimulus(1, 1'b0, 8'h00, 1'b0, 8'h00);
        waitDone(60);

        $display("[TB] reset during data bit 3");
        doReset();
        pushExp(1'b0, 8'h96, 0, 1);
        applyStimulus(1, 1'b1, 8'h96, 1'b0, 8'h00);
        waitAck(1'b0, 10);
        repeat (17) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        pushExp(1'b0, 8'h96, 0, 0);
        rst_n = 1'b1;
        waitAck(1'b0, 10);
        applyStimulus(1, 1'b0, 8'h96, 1'b0, 8'h00);
        waitDone(60);

        $display("[TB] withdrawal and data change");
        doReset();
        pushExp(1'b0, 8'h3B, 0, 0);
        applyStimulus(1, 1'b1, 8'h3B, 1'b0, 8'h00);
        waitAck(1'b0, 10);
        applyStimulus(1, 1'b0, 8'hFF, 1'b0, 8'h00);
        applyStimulus(10, 1'b0, 8'hFF, 1'b1, 8'h11);
        applyStimulus(1, 1'b0, 8'hFF, 1'b0, 8'h11);
        waitDone(60);
        applyStimulus(20, 1'b0, 8'h00, 1'b0, 8'h00);

        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        checks++;
        failures++;
        $display("[TB] FAIL watchdog: got timeout, expected bench completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
